theft_alarm_ctrl: RTL and testbench

- Sequences the bicycle safety detector through the park/lock cycle: arming delay, baseline capture, grace period on trigger, timed alarm, automatic re-arm and lockout.
- Sits between the user key/button logic and the detector. It drives the detector's lock and synchronous reset, reads its unsafe flag, and gates the buzzer enable.

---
 rtl/theft_alarm_ctrl_if.sv | 30 +++
 rtl/theft_alarm_ctrl.sv | 129 ++++++++++++
 tb/tb_theft_alarm_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/theft_alarm_ctrl_if.sv
// ============================================================================
// Module   : theft_alarm_ctrl_if
// Purpose  : Request, detector and status signals of the theft alarm controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface theft_alarm_ctrl_if;
  logic       arm_req;
  logic       disarm_req;
  logic       det_safety;
  logic       det_lock;
  logic       det_rst;
  logic       bell_en;
  logic       armed;
  logic [2:0] state;
  logic [1:0] alarm_cnt;

  modport master (
    output arm_req, disarm_req, det_safety,
    input  det_lock, det_rst, bell_en, armed, state, alarm_cnt
  );

  modport slave (
    input  arm_req, disarm_req, det_safety,
    output det_lock, det_rst, bell_en, armed, state, alarm_cnt
  );
endinterface

`default_nettype wire

// File: rtl/theft_alarm_ctrl.sv
// ============================================================================
// Module   : theft_alarm_ctrl
// Purpose  : Park/lock sequencer for the bicycle detector: arming, grace, alarm, re-arm, lockout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module theft_alarm_ctrl #(
  parameter int ARM_DELAY    = 150_000_000,
  parameter int GRACE        = 250_000_000,
  parameter int ALARM_TIME   = 500_000_000,
  parameter int REARM_CYCLES = 4,
  parameter int MAX_ALARMS   = 3,
  parameter int CNT_W        = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  theft_alarm_ctrl_if.slave     bus
);

  localparam logic [2:0] c_ST_DISARMED = 3'd0;
  localparam logic [2:0] c_ST_ARMING   = 3'd1;
  localparam logic [2:0] c_ST_ARMED    = 3'd2;
  localparam logic [2:0] c_ST_PENDING  = 3'd3;
  localparam logic [2:0] c_ST_ALARM    = 3'd4;
  localparam logic [2:0] c_ST_REARM    = 3'd5;
  localparam logic [2:0] c_ST_LOCKOUT  = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_limit;
  logic             w_timed;
  logic             w_timer_hit;

  logic             r_det_lock,  w_det_lock_nxt;
  logic             r_det_rst,   w_det_rst_nxt;
  logic             r_bell_en,   w_bell_en_nxt;
  logic             r_armed,     w_armed_nxt;
  logic [1:0]       r_alarm_cnt, w_alarm_cnt_nxt;

  // Terminal count of the current timed state; untimed states never consult it.
  always_comb begin
    w_limit = '0;
    w_timed = 1'b1;
    case (r_state)
      c_ST_ARMING:  w_limit = CNT_W'(ARM_DELAY - 1);
      c_ST_PENDING: w_limit = CNT_W'(GRACE - 1);
      c_ST_ALARM:   w_limit = CNT_W'(ALARM_TIME - 1);
      c_ST_REARM:   w_limit = CNT_W'(REARM_CYCLES - 1);
      default:      w_timed = 1'b0;
    endcase
  end

  assign w_timer_hit = (r_timer == w_limit);

  always_comb begin
    w_next_state = r_state;
    if (bus.disarm_req && (r_state != c_ST_DISARMED)) begin
      w_next_state = c_ST_DISARMED;
    end else begin
      case (r_state)
        c_ST_DISARMED: if (bus.arm_req && !bus.disarm_req) w_next_state = c_ST_ARMING;
        c_ST_ARMING:   if (w_timer_hit) w_next_state = c_ST_ARMED;
        c_ST_ARMED:    if (bus.det_safety) w_next_state = c_ST_PENDING;
        c_ST_PENDING:  if (w_timer_hit) w_next_state = c_ST_ALARM;
        c_ST_ALARM: begin
          if (w_timer_hit) begin
            w_next_state = (r_alarm_cnt == 2'(MAX_ALARMS)) ? c_ST_LOCKOUT : c_ST_REARM;
          end
        end
        c_ST_REARM:    if (w_timer_hit) w_next_state = c_ST_ARMED;
        c_ST_LOCKOUT:  w_next_state = c_ST_LOCKOUT;
        default:       w_next_state = c_ST_DISARMED;
      endcase
    end
  end

  // Outputs are decoded from the upcoming state so they change on the same edge as state.
  always_comb begin
    w_det_lock_nxt  = (w_next_state == c_ST_ARMED)  || (w_next_state == c_ST_PENDING) ||
                      (w_next_state == c_ST_ALARM)  || (w_next_state == c_ST_LOCKOUT);
    w_det_rst_nxt   = (w_next_state == c_ST_DISARMED) || (w_next_state == c_ST_REARM);
    w_bell_en_nxt   = (w_next_state == c_ST_ALARM) || (w_next_state == c_ST_LOCKOUT);
    w_armed_nxt     = (w_next_state != c_ST_DISARMED) && (w_next_state != c_ST_ARMING);
    w_alarm_cnt_nxt = r_alarm_cnt;
    if ((w_next_state == c_ST_DISARMED) && (r_state != c_ST_DISARMED) &&
        (r_state != c_ST_PENDING)) begin
      w_alarm_cnt_nxt = 2'd0;
    end else if ((r_state == c_ST_PENDING) && (w_next_state == c_ST_ALARM) &&
                 (r_alarm_cnt != 2'd3)) begin
      w_alarm_cnt_nxt = r_alarm_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_ST_DISARMED;
      r_timer     <= '0;
      r_det_lock  <= 1'b0;
      r_det_rst   <= 1'b1;
      r_bell_en   <= 1'b0;
      r_armed     <= 1'b0;
      r_alarm_cnt <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_det_lock  <= w_det_lock_nxt;
      r_det_rst   <= w_det_rst_nxt;
      r_bell_en   <= w_bell_en_nxt;
      r_armed     <= w_armed_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
      if (w_next_state != r_state) begin
        r_timer <= '0;
      end else if (w_timed) begin
        r_timer <= r_timer + CNT_W'(1);
      end
    end
  end

  assign bus.det_lock  = r_det_lock;
  assign bus.det_rst   = r_det_rst;
  assign bus.bell_en   = r_bell_en;
  assign bus.armed     = r_armed;
  assign bus.state     = r_state;
  assign bus.alarm_cnt = r_alarm_cnt;

endmodule

`default_nettype wire

// File: tb/tb_theft_alarm_ctrl.sv
// ============================================================================
// Module   : tb_theft_alarm_ctrl
// Purpose  : Scoreboard bench for theft_alarm_ctrl against a countdown reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_theft_alarm_ctrl;

  localparam int ARM_DELAY    = 10;
  localparam int GRACE        = 20;
  localparam int ALARM_TIME   = 30;
  localparam int REARM_CYCLES = 4;
  localparam int MAX_ALARMS   = 2;
  localparam int CNT_W        = 32;

  // One bit per mode (bit index = state code) telling whether the output is high there.
  localparam logic [6:0] LOCK_MASK  = 7'b1011100;
  localparam logic [6:0] DRST_MASK  = 7'b0100001;
  localparam logic [6:0] BELL_MASK  = 7'b1010000;
  localparam logic [6:0] ARMED_MASK = 7'b1111100;

  typedef struct {
    logic [2:0] st;
    logic       lock;
    logic       drst;
    logic       bell;
    logic       armd;
    logic [1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  theft_alarm_ctrl_if bus();

  theft_alarm_ctrl #(
    .ARM_DELAY    (ARM_DELAY),
    .GRACE        (GRACE),
    .ALARM_TIME   (ALARM_TIME),
    .REARM_CYCLES (REARM_CYCLES),
    .MAX_ALARMS   (MAX_ALARMS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_mode = 0;
  int   m_left = 0;
  int   m_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st   = 3'(m_mode);
    e.lock = LOCK_MASK[m_mode];
    e.drst = DRST_MASK[m_mode];
    e.bell = BELL_MASK[m_mode];
    e.armd = ARMED_MASK[m_mode];
    e.cnt  = 2'(m_cnt);
    return e;
  endfunction

  // Mode advances with a countdown of remaining cycles in the current phase.
  task automatic model_step(input bit a, input bit d, input bit s);
    if (d && m_mode != 0) begin
      if (m_mode != 3) m_cnt = 0;
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (a && !d) begin m_mode = 1; m_left = ARM_DELAY; end
        1: begin m_left--; if (m_left == 0) m_mode = 2; end
        2: if (s) begin m_mode = 3; m_left = GRACE; end
        3: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = 4;
            m_left = ALARM_TIME;
            if (m_cnt < 3) m_cnt++;
          end
        end
        4: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = (m_cnt == MAX_ALARMS) ? 6 : 5;
            m_left = REARM_CYCLES;
          end
        end
        5: begin m_left--; if (m_left == 0) m_mode = 2; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit a, input bit d, input bit s);
    @(posedge clk);
    #2;
    bus.arm_req    = a;
    bus.disarm_req = d;
    bus.det_safety = s;
    model_step(a, d, s);
    sbq.push_back(model_out());
  endtask

  task automatic do_reset_async(input int ncyc);
    @(posedge clk);
    #2;
    rst            = 1'b0;
    bus.arm_req    = 1'b0;
    bus.disarm_req = 1'b0;
    bus.det_safety = 1'b0;
    #1;
    chk("async_state", bus.state, 0);
    chk("async_bell", bus.bell_en, 0);
    chk("async_lock", bus.det_lock, 0);
    chk("async_drst", bus.det_rst, 1);
    chk("async_cnt", bus.alarm_cnt, 0);
    m_mode = 0;
    m_cnt  = 0;
    m_left = 0;
    repeat (ncyc) begin
      sbq.push_back(model_out());
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    sbq.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_state", bus.state, e.st);
        chk("sb_det_lock", bus.det_lock, e.lock);
        chk("sb_det_rst", bus.det_rst, e.drst);
        chk("sb_bell_en", bus.bell_en, e.bell);
        chk("sb_armed", bus.armed, e.armd);
        chk("sb_alarm_cnt", bus.alarm_cnt, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit a, d, s;
    rst            = 1'b0;
    bus.arm_req    = 1'b0;
    bus.disarm_req = 1'b0;
    bus.det_safety = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_det_lock", bus.det_lock, 0);
    chk("rst_det_rst", bus.det_rst, 1);
    chk("rst_bell_en", bus.bell_en, 0);
    chk("rst_armed", bus.armed, 0);
    chk("rst_alarm_cnt", bus.alarm_cnt, 0);
    #1;
    rst = 1'b1;
    sbq.push_back(model_out());

    // arm and reach ARMED
    repeat (4) step(0, 0, 0);
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);

    // trigger then cancel inside the grace window
    step(0, 0, 1);
    repeat (9) step(0, 0, 0);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // safety held through arming, alarm, rearm, second alarm and lockout
    step(1, 0, 1);
    repeat (330) step(0, 0, 1);
    step(0, 1, 0);
    repeat (3) step(0, 0, 0);

    // simultaneous requests in DISARMED and in ARMING
    step(1, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 1, 0);
    repeat (2) step(0, 0, 0);

    // asynchronous reset in the middle of an alarm
    step(1, 0, 0);
    repeat (11) step(0, 0, 0);
    step(0, 0, 1);
    repeat (25) step(0, 0, 0);
    do_reset_async(3);

    // randomized traffic
    repeat (3000) begin
      a = ($urandom_range(0, 99) < 6);
      d = ($urandom_range(0, 199) < 3);
      s = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 999) == 0) do_reset_async(2);
      else step(a, d, s);
    end

    @(posedge clk);
    #3;
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
